is_uart_rx: RTL and testbench
=============================

Name: is_uart_rx

Overview:
UART receive front end. It sits directly upstream of the UART controller FSM.
- Oversamples the asynchronous serial line and deframes start, data, optional parity and stop bits.
- Delivers each received character as a one-cycle strobe plus a 10-bit word {frame_err, parity_err, data[7:0]}.
- The FSM consumes the word on its rx_data_en_i / rx_data_r_i inputs.
- There is no backpressure: the consumer must accept every strobe.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200); legal range ≥ 4.
DATA_W, 8, data bits per frame, sent LSB first; fixed at 8 for the 10-bit output packing.
PARITY_EN, 1, 1 means a parity bit follows the data bits; 0 means no parity bit.
PARITY_ODD, 0, 0 selects even parity; 1 selects odd parity.

Ports:
clk_i  in  1  system clock, single clock domain.
rstn_i  in  1  reset, asynchronous, active-low.
rx_i  in  1  serial line, asynchronous to clk_i, idles high.
rx_data_en_o  out  1  one-cycle strobe: rx_data_r_o holds a new character.
rx_data_r_o  out  10  [9] frame error, [8] parity error, [7:0] received data.
rx_busy_o  out  1  high while a frame is being received (any state other than IDLE).

Behaviour:
- Synchronizer: rx_i passes through 2 flops (both reset to 1), giving rx_s. A third flop holds rx_prev (reset 1).
- Start detect: IDLE requires the falling edge rx_prev=1 and rx_s=0. A line already low when reset is released therefore starts nothing until it goes high and then low again.
- Bit counter: cnt counts clock cycles within a bit. HALF = CLKS_PER_BIT/2, rounded down.
- Reset values: all outputs 0, state IDLE, cnt 0, shift register 0, error flags 0.
- IDLE:
  - On a falling edge: cnt←0, go to START.
- START:
  - When cnt = HALF-1, sample rx_s.
  - If rx_s=1: glitch; return to IDLE, no strobe.
  - If rx_s=0: cnt←0, bit index←0, go to DATA.
- DATA:
  - When cnt = CLKS_PER_BIT-1, sample rx_s into shift register position [bit index] (LSB first), cnt←0.
  - After DATA_W samples, go to PARITY if PARITY_EN=1, otherwise STOP.
- PARITY:
  - When cnt = CLKS_PER_BIT-1, sample the parity bit.
  - pe = (XOR of data bits XOR parity bit) XOR PARITY_ODD, so pe=1 on mismatch.
  - Go to STOP.
  - When PARITY_EN=0, pe is forced to 0.
- STOP:
  - When cnt = CLKS_PER_BIT-1, sample the stop bit. fe = ~rx_s.
  - On the next clock: rx_data_r_o ← {fe, pe, data}, rx_data_en_o=1 for exactly one cycle.
  - If fe=0, return to IDLE, i.e. mid-stop-bit.
  - If fe=1, go to BREAK.
- BREAK:
  - Wait until rx_s=1, then go to IDLE. No strobes are produced while the line stays low.
- Output hold: rx_data_r_o keeps its value until the next strobe. A frame with errors still updates it and still strobes.
- Back-to-back frames: IDLE is re-entered at mid-stop, so a start edge arriving right after a full stop bit is detected; zero idle time between frames is supported.
- Latency:
  - From the rx_i falling edge to the strobe = 2 (sync) + 1 (edge detect) + HALF + (DATA_W + PARITY_EN + 1)·CLKS_PER_BIT + 1 cycles.
  - Tolerance ±1 cycle on the sync term only.
- Reset mid-frame: returns to IDLE immediately with outputs at 0. The partial frame is discarded and no strobe is produced.
- rx_busy_o=1 in START, DATA, PARITY, STOP and BREAK.

Test Plan:
All scenarios use CLKS_PER_BIT=16 and 8E1 framing unless stated.
1. Send 0xA5 with parity bit 0 -> exactly one strobe, rx_data_r_o=10'h0A5, strobe at the computed latency (2+1+8+10·16+1 = 172 cycles, ±1).
2. Send 0x3C with parity bit 1 -> rx_data_r_o=10'h13C. Send 0x0D with stop bit 0, then hold the line low for 3 bit times -> rx_data_r_o=10'h20D, no further strobes, rx_busy_o stays 1 until the line returns high.
3. Send 0x0A with parity bit 1 and stop bit 0 -> rx_data_r_o=10'h30A. Then send 0x55 correctly -> 10'h055.
4. Low glitch of 4 clocks on an idle line -> no strobe, rx_busy_o returns to 0 within HALF+3 cycles. Assert rstn_i mid-way through the data bits -> outputs 0, no strobe; the next valid frame 0xFF -> 10'h0FF.
5. Two frames 0x31, 0x0D back-to-back with no idle time -> two strobes 10'h031, 10'h00D spaced 11·16 = 176 cycles apart.
6. PARITY_EN=0 (8N1), send 0x80 -> 10'h080, strobe 16 cycles earlier than in scenario 1. PARITY_ODD=1, send 0x01 with parity bit 0 -> 10'h001.

Source files
------------

// File: rtl/is_uart_rx.sv
// UART receive front end: oversamples rx_i, deframes start/data/parity/stop and
// hands each character to the controller as a one-cycle strobe plus {fe, pe, data}.
module is_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 8,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        rx_i,
    output logic        rx_data_en_o,
    output logic [9:0]  rx_data_r_o,
    output logic        rx_busy_o
);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, rx_s, rx_prev_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   bit_idx_q;
    logic [DATA_W-1:0]  shift_q;
    logic               pe_q, fe_q, deliver_q;
    logic               bit_tick;
    logic               start_ok, sample_data, sample_par, sample_stop;

    assign bit_tick  = (cnt_q == BIT_M1);
    assign rx_busy_o = (state_q != ST_IDLE);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sync1_q   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync1_q   <= rx_i;
            rx_s      <= sync1_q;
            rx_prev_q <= rx_s;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        start_ok    = 1'b0;
        sample_data = 1'b0;
        sample_par  = 1'b0;
        sample_stop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_DATA;
                        start_ok = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    cnt_d       = '0;
                    sample_data = 1'b1;
                    if (bit_idx_q == LAST_IDX) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    cnt_d      = '0;
                    sample_par = 1'b1;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop lets a start edge right after the stop bit be seen.
                if (bit_tick) begin
                    cnt_d       = '0;
                    sample_stop = 1'b1;
                    state_d     = rx_s ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bit_idx_q    <= '0;
            shift_q      <= '0;
            pe_q         <= 1'b0;
            fe_q         <= 1'b0;
            deliver_q    <= 1'b0;
            rx_data_en_o <= 1'b0;
            rx_data_r_o  <= '0;
        end else begin
            if (start_ok) begin
                bit_idx_q <= '0;
                pe_q      <= 1'b0;
            end else if (sample_data) begin
                bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
            if (sample_data) shift_q[bit_idx_q] <= rx_s;
            if (sample_par) pe_q <= (^shift_q) ^ rx_s ^ PARITY_ODD;
            if (sample_stop) fe_q <= ~rx_s;
            // Word is published one clock after the stop sample so fe is already registered.
            deliver_q    <= sample_stop;
            rx_data_en_o <= deliver_q;
            if (deliver_q) rx_data_r_o <= {fe_q, pe_q, shift_q};
        end
    end
endmodule

// File: tb/tb_is_uart_rx.sv
// Bench for is_uart_rx: three instances (8E1, 8N1, 8O1 at 16 clocks/bit) driven by
// directed and random frames, checked against a bit-level framing model.
module tb_is_uart_rx;
    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    typedef struct packed {
        logic [1:0]  dut;
        logic [9:0]  w;
        logic [31:0] t;
    } ev_t;

    logic       clk;
    logic       rstn;
    logic       rx_line [3];
    logic       en      [3];
    logic [9:0] dw      [3];
    logic       busy    [3];
    int         cyc;
    int         checks;
    int         errors;
    int         last_t;
    ev_t        ev_q[$];

    is_uart_rx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
        .clk_i(clk), .rstn_i(rstn), .rx_i(rx_line[0]),
        .rx_data_en_o(en[0]), .rx_data_r_o(dw[0]), .rx_busy_o(busy[0]));
    is_uart_rx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_none (
        .clk_i(clk), .rstn_i(rstn), .rx_i(rx_line[1]),
        .rx_data_en_o(en[1]), .rx_data_r_o(dw[1]), .rx_busy_o(busy[1]));
    is_uart_rx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
        .clk_i(clk), .rstn_i(rstn), .rx_i(rx_line[2]),
        .rx_data_en_o(en[2]), .rx_data_r_o(dw[2]), .rx_busy_o(busy[2]));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // strobe monitor, sampled away from the active edge
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (en[i] === 1'b1) ev_q.push_back({2'(i), dw[i], 32'(cyc)});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // reference model: dut 0 even parity, 1 no parity, 2 odd parity
    function automatic logic [9:0] model(input int d, input logic [7:0] data,
                                         input logic par_bit, input logic stop_bit);
        int   ones;
        logic correct;
        logic pe;
        ones = $countones(data);
        pe   = 1'b0;
        if (d != 1) begin
            correct = (d == 2) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            pe      = (par_bit != correct);
        end
        return {~stop_bit, pe, data};
    endfunction

    function automatic int latency(input int d);
        return 2 + 1 + HALF + (8 + ((d != 1) ? 1 : 0) + 1) * CPB + 1;
    endfunction

    // driver tasks
    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input int d, input logic b);
        rx_line[d] = b;
        idle_cycles(CPB);
    endtask

    task automatic send_frame(input int d, input logic [7:0] data,
                              input logic par_bit, input logic stop_bit);
        drive_bit(d, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d, data[i]);
        if (d != 1) drive_bit(d, par_bit);
        drive_bit(d, stop_bit);
    endtask

    task automatic expect_frame(input string tag, input int d, input logic [7:0] data,
                                input logic par_bit, input logic stop_bit,
                                input int t0, input bit chk_lat);
        ev_t e;
        check({tag, "_count"}, ev_q.size(), 1);
        if (ev_q.size() > 0) begin
            e = ev_q.pop_front();
            check({tag, "_dut"}, e.dut, d);
            check({tag, "_word"}, e.w, model(d, data, par_bit, stop_bit));
            if (chk_lat) check_range({tag, "_lat"}, int'(e.t) - t0, latency(d) - 1, latency(d) + 1);
            last_t = int'(e.t);
        end
        check({tag, "_hold"}, dw[d], model(d, data, par_bit, stop_bit));
        ev_q.delete();
    endtask

    initial begin
        int          t0;
        int          t1;
        int          n;
        int          low_cnt;
        logic [7:0]  rdata;
        logic        rpar;
        logic        rstop;

        checks = 0;
        errors = 0;
        last_t = 0;
        for (int i = 0; i < 3; i++) rx_line[i] = 1'b1;
        rstn = 1'b0;
        idle_cycles(3);
        for (int i = 0; i < 3; i++) begin
            check("rst_en", en[i], 1'b0);
            check("rst_word", dw[i], 10'h000);
            check("rst_busy", busy[i], 1'b0);
        end
        rstn = 1'b1;
        idle_cycles(5);
        check("idle_busy", busy[0], 1'b0);

        // 1: clean 8E1 frame with latency
        t0 = cyc;
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        expect_frame("a5", 0, 8'hA5, 1'b0, 1'b1, t0, 1'b1);
        check("a5_exact", dw[0], 10'h0A5);

        // 2: parity error, then framing error followed by a held break
        t0 = cyc;
        send_frame(0, 8'h3C, 1'b1, 1'b1);
        expect_frame("3c", 0, 8'h3C, 1'b1, 1'b1, t0, 1'b1);
        check("3c_exact", dw[0], 10'h13C);
        t0 = cyc;
        send_frame(0, 8'h0D, 1'b1, 1'b0);
        expect_frame("0d_fe", 0, 8'h0D, 1'b1, 1'b0, t0, 1'b1);
        check("0d_exact", dw[0], 10'h20D);
        low_cnt = 0;
        for (int i = 0; i < 3 * CPB; i++) begin
            idle_cycles(1);
            if (busy[0] !== 1'b1) low_cnt++;
        end
        check("break_busy_low_cycles", low_cnt, 0);
        check("break_no_strobe", ev_q.size(), 0);
        rx_line[0] = 1'b1;
        n = 0;
        while (busy[0] === 1'b1 && n < 10) begin
            idle_cycles(1);
            n++;
        end
        check_range("break_release", n, 1, 4);
        idle_cycles(CPB);
        check("break_release_no_strobe", ev_q.size(), 0);

        // 3: both errors, then a clean frame
        t0 = cyc;
        send_frame(0, 8'h0A, 1'b1, 1'b0);
        expect_frame("0a", 0, 8'h0A, 1'b1, 1'b0, t0, 1'b1);
        check("0a_exact", dw[0], 10'h30A);
        drive_bit(0, 1'b1);
        t0 = cyc;
        send_frame(0, 8'h55, 1'b0, 1'b1);
        expect_frame("55", 0, 8'h55, 1'b0, 1'b1, t0, 1'b1);
        check("55_exact", dw[0], 10'h055);

        // 4: short glitch, then reset in the middle of the data bits
        rx_line[0] = 1'b0;
        idle_cycles(4);
        check("glitch_busy", busy[0], 1'b1);
        rx_line[0] = 1'b1;
        n = 0;
        while (busy[0] === 1'b1 && n < 40) begin
            idle_cycles(1);
            n++;
        end
        check_range("glitch_recover", n, 0, HALF + 3);
        idle_cycles(CPB);
        check("glitch_no_strobe", ev_q.size(), 0);
        check("glitch_hold", dw[0], 10'h055);

        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        rx_line[0] = 1'b1;
        rstn = 1'b0;
        #1;
        check("midrst_en", en[0], 1'b0);
        check("midrst_word", dw[0], 10'h000);
        check("midrst_busy", busy[0], 1'b0);
        idle_cycles(3);
        rstn = 1'b1;
        idle_cycles(12 * CPB);
        check("midrst_no_strobe", ev_q.size(), 0);
        t0 = cyc;
        send_frame(0, 8'hFF, 1'b0, 1'b1);
        expect_frame("ff", 0, 8'hFF, 1'b0, 1'b1, t0, 1'b1);
        check("ff_exact", dw[0], 10'h0FF);

        // 5: back-to-back frames with no idle time
        send_frame(0, 8'h31, 1'b1, 1'b1);
        expect_frame("b2b_31", 0, 8'h31, 1'b1, 1'b1, 0, 1'b0);
        t1 = last_t;
        send_frame(0, 8'h0D, 1'b1, 1'b1);
        expect_frame("b2b_0d", 0, 8'h0D, 1'b1, 1'b1, 0, 1'b0);
        check("b2b_spacing", last_t - t1, 11 * CPB);
        check("b2b_exact", dw[0], 10'h00D);

        // 6: 8N1 latency and odd parity
        t0 = cyc;
        send_frame(1, 8'h80, 1'b0, 1'b1);
        expect_frame("n_80", 1, 8'h80, 1'b0, 1'b1, t0, 1'b1);
        check("n_80_exact", dw[1], 10'h080);
        t0 = cyc;
        send_frame(2, 8'h01, 1'b0, 1'b1);
        expect_frame("o_01", 2, 8'h01, 1'b0, 1'b1, t0, 1'b1);
        check("o_01_exact", dw[2], 10'h001);

        // random frames on every framing variant
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 5; k++) begin
                rdata = 8'($urandom_range(0, 255));
                rpar  = 1'($urandom_range(0, 1));
                rstop = ($urandom_range(0, 3) != 0);
                idle_cycles($urandom_range(0, 8));
                t0 = cyc;
                send_frame(d, rdata, rpar, rstop);
                expect_frame("rand", d, rdata, rpar, rstop, t0, 1'b1);
                if (!rstop) begin
                    drive_bit(d, 1'b1);
                    check("rand_break_exit", busy[d], 1'b0);
                end
            end
        end

        idle_cycles(CPB);
        check("final_no_strobe", ev_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
